// File: rtl/sigmoid_backward_if.sv
// Streaming bus for sigmoid_backward: input beats (y, gradient, last) and
// output beats (input gradient, last) with valid/ready, plus the beat counter.
interface sigmoid_backward_if #(
   parameter int Y_W    = 8,
   parameter int GRAD_W = 8,
   parameter int CNT_W  = 16
);
   logic                     in_valid;
   logic                     in_ready;
   logic        [Y_W-1:0]    y_in;
   logic signed [GRAD_W-1:0] grad_in;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [GRAD_W-1:0] grad_out;
   logic                     out_last;
   logic        [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, y_in, grad_in, in_last, out_ready,
      input  in_ready, out_valid, grad_out, out_last, out_count
   );

   modport slave (
      input  in_valid, y_in, grad_in, in_last, out_ready,
      output in_ready, out_valid, grad_out, out_last, out_count
   );
endinterface

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad_out = round(g * y * (1 - y)) as a 3-stage
// valid/ready pipeline with full backpressure and an output beat counter.
module sigmoid_backward #(
   parameter int Y_W    = 8,
   parameter int GRAD_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   sigmoid_backward_if.slave  s_if
);
   localparam int D_W = 2 * Y_W;
   localparam int P_W = GRAD_W + 2 * Y_W + 1;
   localparam logic signed [P_W-1:0] HALF_LSB = P_W'(1) <<< (D_W - 1);

   // Stage registers
   logic                     r_v1, r_v2, r_v3;
   logic        [D_W-1:0]    r1_d;
   logic signed [GRAD_W-1:0] r1_g;
   logic                     r1_last;
   logic signed [P_W-1:0]    r2_p;
   logic                     r2_last;
   logic signed [GRAD_W-1:0] r3_g;
   logic                     r3_last;
   logic        [CNT_W-1:0]  r_count;

   logic                     w_ld1, w_ld2, w_ld3;
   logic                     w_out_hs;
   logic        [Y_W:0]      w_one_minus_y;
   logic        [D_W-1:0]    w_d;
   logic signed [P_W-1:0]    w_g_ext, w_d_ext, w_p, w_rnd;
   logic signed [GRAD_W-1:0] w_grad;

   // A stage may load when it is empty or its contents move on this cycle;
   // the chain starts at out_ready so in_ready never depends on in_valid.
   assign w_ld3    = !r_v3 || s_if.out_ready;
   assign w_ld2    = !r_v2 || w_ld3;
   assign w_ld1    = !r_v1 || w_ld2;
   assign w_out_hs = r_v3 && s_if.out_ready;

   // d = y * (2^Y_W - y); the peak 2^(2*Y_W-2) fits comfortably in D_W bits
   assign w_one_minus_y = {1'b1, {Y_W{1'b0}}} - {1'b0, s_if.y_in};
   assign w_d           = D_W'(s_if.y_in) * D_W'(w_one_minus_y);

   assign w_g_ext = P_W'(r1_g);
   assign w_d_ext = P_W'(r1_d);
   assign w_p     = w_g_ext * w_d_ext;

   // Adding half an output LSB before the arithmetic shift rounds half toward +inf
   assign w_rnd  = r2_p + HALF_LSB;
   assign w_grad = GRAD_W'(w_rnd >>> D_W);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r1_d    <= '0;
         r1_g    <= '0;
         r1_last <= 1'b0;
         r2_p    <= '0;
         r2_last <= 1'b0;
         r3_g    <= '0;
         r3_last <= 1'b0;
         r_count <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage read the previous
         // cycle's neighbour values regardless of statement order.
         if (w_ld1) begin
            r_v1 <= s_if.in_valid;
            if (s_if.in_valid) begin
               r1_d    <= w_d;
               r1_g    <= s_if.grad_in;
               r1_last <= s_if.in_last;
            end
         end
         if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r2_p    <= w_p;
               r2_last <= r1_last;
            end
         end
         if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
               r3_g    <= w_grad;
               r3_last <= r2_last;
            end
         end
         if (w_out_hs) r_count <= r_count + CNT_W'(1);
      end
   end

   assign s_if.in_ready  = w_ld1;
   assign s_if.out_valid = r_v3;
   assign s_if.grad_out  = r3_g;
   assign s_if.out_last  = r3_last;
   assign s_if.out_count = r_count;
endmodule

// File: tb/tb_sigmoid_backward.sv
// Self-checking bench for sigmoid_backward: scoreboard of model results pushed
// on input handshakes and compared on output handshakes, plus scenario checks.
module tb_sigmoid_backward;
   localparam int Y_W    = 8;
   localparam int GRAD_W = 8;

   typedef struct {
      logic signed [GRAD_W-1:0] g;
      logic                     last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sigmoid_backward_if #(.Y_W(Y_W), .GRAD_W(GRAD_W), .CNT_W(16)) bif ();
   sigmoid_backward_if #(.Y_W(Y_W), .GRAD_W(GRAD_W), .CNT_W(4))  wif ();

   sigmoid_backward #(.Y_W(Y_W), .GRAD_W(GRAD_W), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (rst),
      .s_if  (bif)
   );

   sigmoid_backward #(.Y_W(Y_W), .GRAD_W(GRAD_W), .CNT_W(4)) dut_wrap (
      .clk   (clk),
      .reset (rst),
      .s_if  (wif)
   );

   int   total   = 0;
   int   bad     = 0;
   int   out_hs  = 0;
   int   wrap_hs = 0;
   exp_t sb[$];
   exp_t e;

   // Golden model: exact integer form of g*y*(1-y) with round-half-up
   function automatic logic signed [GRAD_W-1:0] model(input int y, input int g);
      longint d, p;
      d = longint'(y) * ((longint'(1) << Y_W) - longint'(y));
      p = longint'(g) * d;
      return GRAD_W'((p + (longint'(1) << (2 * Y_W - 1))) >>> (2 * Y_W));
   endfunction

   // Scoreboard: pop before push so an unexpected beat cannot consume a fresh entry
   always @(negedge clk) begin
      if (!rst) begin
         if (bif.out_valid && bif.out_ready) begin
            out_hs++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected: got grad_out=%0d last=%b, want no beat",
                        bif.grad_out, bif.out_last);
            end else begin
               e = sb.pop_front();
               if (bif.grad_out !== e.g || bif.out_last !== e.last) begin
                  bad++;
                  $display("FAIL sb_beat: got grad_out=%0d last=%b, want grad_out=%0d last=%b",
                           bif.grad_out, bif.out_last, e.g, e.last);
               end
            end
         end
         if (bif.in_valid && bif.in_ready)
            sb.push_back('{g: model(int'(bif.y_in), int'(bif.grad_in)), last: bif.in_last});
      end
   end

   always @(negedge clk) begin
      if (!rst && wif.out_valid && wif.out_ready) wrap_hs++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [Y_W-1:0] y, input logic signed [GRAD_W-1:0] g,
                       input logic last);
      int n = 0;
      bif.y_in     = y;
      bif.grad_in  = g;
      bif.in_last  = last;
      bif.in_valid = 1'b1;
      @(negedge clk);
      while (!bif.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bif.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 for 200 cycles, want 1");
      end
      tick();
      bif.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d beats pending, want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      total += 3;
      if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bif.out_valid); end
      if (bif.grad_out !== '0) begin bad++; $display("FAIL rst_grad_out: got %0d want 0", bif.grad_out); end
      if (bif.out_count !== '0) begin bad++; $display("FAIL rst_out_count: got %0d want 0", bif.out_count); end
      rst = 1'b0;
      tick();
      total++;
      if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bif.in_ready); end
   endtask

   task automatic test_stream();
      bif.out_ready = 1'b1;
      send(8'd128, 8'sd100, 1'b0);
      total++;
      if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL lat_n1: got out_valid=%b want 0", bif.out_valid); end
      tick();
      total++;
      if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL lat_n2: got out_valid=%b want 0", bif.out_valid); end
      tick();
      total += 2;
      if (bif.out_valid !== 1'b1) begin bad++; $display("FAIL lat_n3: got out_valid=%b want 1", bif.out_valid); end
      if (bif.grad_out !== 8'sd25) begin bad++; $display("FAIL first_value: got %0d want 25", bif.grad_out); end
      send(8'd128, -8'sd128, 1'b0);
      send(8'd64,  -8'sd100, 1'b0);
      send(8'd255,  8'sd127, 1'b0);
      send(8'd0,   -8'sd128, 1'b1);
      wait_drain();
      total++;
      if (bif.out_count !== 16'd5) begin bad++; $display("FAIL stream_count: got %0d want 5", bif.out_count); end
   endtask

   task automatic test_reset_mid();
      int h;
      bif.out_ready = 1'b0;
      send(8'd128, 8'sd100, 1'b0);
      send(8'd64, -8'sd100, 1'b1);
      tick();
      total++;
      if (bif.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", bif.out_valid); end
      rst = 1'b1;
      #1;
      sb.delete();
      total += 3;
      if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", bif.out_valid); end
      if (bif.grad_out !== '0) begin bad++; $display("FAIL mid_grad_out: got %0d want 0", bif.grad_out); end
      if (bif.out_count !== '0) begin bad++; $display("FAIL mid_out_count: got %0d want 0", bif.out_count); end
      tick();
      tick();
      rst = 1'b0;
      tick();
      total++;
      if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", bif.in_ready); end
      bif.out_ready = 1'b1;
      h = out_hs;
      repeat (10) tick();
      total++;
      if (out_hs !== h) begin bad++; $display("FAIL mid_stale: got %0d beats after reset, want 0", out_hs - h); end
   endtask

   task automatic test_backpressure();
      logic signed [GRAD_W-1:0] first;
      first = model(10, 20);
      bif.out_ready = 1'b0;
      send(8'd10,  8'sd20,  1'b0);
      send(8'd200, -8'sd50, 1'b0);
      send(8'd128, 8'sd77,  1'b0);
      bif.y_in = 8'd30; bif.grad_in = -8'sd128; bif.in_last = 1'b0; bif.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total += 3;
         if (bif.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bif.in_ready); end
         if (bif.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", bif.out_valid); end
         if (bif.grad_out !== first) begin bad++; $display("FAIL bp_stable: got %0d want %0d", bif.grad_out, first); end
         tick();
      end
      bif.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (bif.out_valid !== 1'b1) begin bad++; $display("FAIL bp_gap: got out_valid=%b want 1 at drain %0d", bif.out_valid, k); end
         if (k == 0) begin
            total++;
            if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL bp_reassert: got in_ready=%b want 1", bif.in_ready); end
         end
         tick();
         if (k == 0) begin bif.y_in = 8'd90; bif.grad_in = 8'sd111; bif.in_last = 1'b1; end
         if (k == 1) bif.in_valid = 1'b0;
      end
      @(negedge clk);
      total++;
      if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got out_valid=%b want 0", bif.out_valid); end
      tick();
      wait_drain();
   endtask

   task automatic test_random();
      int  h;
      bit  done = 1'b0;
      logic [Y_W-1:0] y;
      rst = 1'b1;
      #1;
      sb.delete();
      tick();
      rst = 1'b0;
      tick();
      h = out_hs;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               repeat ($urandom_range(0, 2)) tick();
               y = (i % 50 == 0) ? 8'd0 : (i % 50 == 1) ? 8'd255 : 8'($urandom_range(0, 255));
               send(y, GRAD_W'($urandom), (i % 8) == 7);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               bif.out_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      bif.out_ready = 1'b1;
      wait_drain();
      total += 2;
      if (bif.out_count !== 16'd1000) begin bad++; $display("FAIL rand_count: got %0d want 1000", bif.out_count); end
      if (out_hs - h !== 1000) begin bad++; $display("FAIL rand_beats: got %0d want 1000", out_hs - h); end
   endtask

   task automatic test_wrap();
      int n_in  = 0;
      int guard = 0;
      wif.out_ready = 1'b1;
      wif.y_in      = 8'd128;
      wif.grad_in   = 8'sd100;
      wif.in_last   = 1'b0;
      wif.in_valid  = 1'b1;
      while (n_in < 17 && guard < 200) begin
         @(negedge clk);
         if (wif.in_ready) n_in++;
         tick();
         guard++;
      end
      wif.in_valid = 1'b0;
      guard = 0;
      while (wrap_hs < 17 && guard < 200) begin
         tick();
         guard++;
      end
      total += 3;
      if (wrap_hs !== 17) begin bad++; $display("FAIL wrap_beats: got %0d want 17", wrap_hs); end
      if (wif.out_count !== 4'd1) begin bad++; $display("FAIL wrap_count: got %0d want 1", wif.out_count); end
      if (wif.grad_out !== 8'sd25) begin bad++; $display("FAIL wrap_value: got %0d want 25", wif.grad_out); end
   endtask

   task automatic test_back_to_back();
      int h;
      bif.out_ready = 1'b0;
      send(8'd100, 8'sd60,  1'b0);
      send(8'd150, -8'sd90, 1'b0);
      send(8'd1,   8'sd127, 1'b0);
      bif.out_ready = 1'b1;
      h = out_hs;
      for (int k = 0; k < 10; k++) begin
         bif.y_in     = 8'($urandom_range(0, 255));
         bif.grad_in  = GRAD_W'($urandom);
         bif.in_last  = (k == 9);
         bif.in_valid = 1'b1;
         @(negedge clk);
         total += 2;
         if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1 at cycle %0d", bif.in_ready, k); end
         if (bif.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid: got %b want 1 at cycle %0d", bif.out_valid, k); end
         tick();
      end
      bif.in_valid = 1'b0;
      total++;
      if (out_hs - h !== 10) begin bad++; $display("FAIL b2b_rate: got %0d outputs in 10 cycles, want 10", out_hs - h); end
      wait_drain();
   endtask

   initial begin
      bif.in_valid = 1'b0; bif.y_in = '0; bif.grad_in = '0; bif.in_last = 1'b0; bif.out_ready = 1'b0;
      wif.in_valid = 1'b0; wif.y_in = '0; wif.grad_in = '0; wif.in_last = 1'b0; wif.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_reset_mid();
      test_backpressure();
      test_random();
      test_wrap();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by time limit, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
